// File: rtl/vga_lcd_pkg.sv
// rtl/vga_lcd_pkg.sv - shared encodings, state type and helpers for the vga_lcd pixel pipe
//
// Contents:
//   DIV_1/DIV_2/DIV_4/DIV_8 : div_sel encodings for the drain rate
//   UCNT_W                  : width of the underflow counter
//   pipe_state_t            : PRIME/RUN drain state
//   div_last()              : terminal count of the 3-bit drain counter for a div_sel code

package vga_lcd_pkg;

    localparam logic [1:0] DIV_1 = 2'b00;
    localparam logic [1:0] DIV_2 = 2'b01;
    localparam logic [1:0] DIV_4 = 2'b10;
    localparam logic [1:0] DIV_8 = 2'b11;

    localparam int UCNT_W = 16;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } pipe_state_t;

    // The drain counter ticks when it reaches this value, then wraps to 0.
    function automatic logic [2:0] div_last(input logic [1:0] sel);
        logic [2:0] last;
        case (sel)
            DIV_1:   last = 3'd0;
            DIV_2:   last = 3'd1;
            DIV_4:   last = 3'd3;
            default: last = 3'd7;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/vga_lcd_fifo.sv
// rtl/vga_lcd_fifo.sv - show-ahead word FIFO between the upstream stage and pal_dac
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers and count)
//   clr        : synchronous clear of pointers and count
//   wreq, d    : write request and write word (ignored when full)
//   rreq, q    : read request (ignored when empty); q always shows the head word
//   nword      : occupancy, 0..2^AW

module vga_lcd_fifo #(
    parameter int DATA_W = 12,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wreq,
    input  logic [DATA_W-1:0] d,
    input  logic              rreq,
    output logic [DATA_W-1:0] q,
    output logic [AW:0]       nword
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              do_w;
    logic              do_r;

    // A read on an empty FIFO is dropped even if a write lands the same cycle,
    // so a freshly written word only becomes readable on the following cycle.
    assign do_w = wreq && (nword != FULL_CNT);
    assign do_r = rreq && (nword != '0);
    assign q    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_w) begin
            mem[wptr] <= d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            nword <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            nword <= '0;
        end else begin
            if (do_w) begin
                wptr <= wptr + 1'b1;
            end
            if (do_r) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_w, do_r})
                2'b10:   nword <= nword + 1'b1;
                2'b01:   nword <= nword - 1'b1;
                default: nword <= nword;
            endcase
        end
    end

endmodule

// File: rtl/vga_lcd_pipe.sv
// rtl/vga_lcd_pipe.sv - flow-controlled FIFO stage from crtc/sequencer to pal_dac
//
// Build option: VGA_LCD_UNDERFLOW_CNT_EN includes the saturating underflow counter;
// without it underflow_cnt reads 0 and the state behaviour is unchanged.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   div_sel       : drain rate 00 /1, 01 /2, 10 /4, 11 /8 (applied at counter wrap)
//   up_dat        : upstream word, written on every cycle with en_up=1
//   up_stb_i      : raw upstream memory strobe
//   en_up         : upstream stage enable
//   csr_stb_o     : memory strobe gated by en_up
//   dn_dat, dn_en : word and enable pulse towards pal_dac
//   nword         : FIFO occupancy
//   mem_busy      : a memory cycle is still in flight
//   underflow_cnt : drain ticks that found the FIFO empty (saturating)

module vga_lcd_pipe
    import vga_lcd_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int AW       = 4,
    parameter int LAT      = 4,
    parameter int LOW_MARK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        div_sel,
    input  logic [DATA_W-1:0] up_dat,
    input  logic              up_stb_i,
    output logic              en_up,
    output logic              csr_stb_o,
    output logic [DATA_W-1:0] dn_dat,
    output logic              dn_en,
    output logic [AW:0]       nword,
    output logic              mem_busy,
    output logic [15:0]       underflow_cnt
);

    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] LOW_CNT  = (AW+1)'(LOW_MARK);

    logic [LAT-1:0]    mem_pipe;
    logic [LAT:0]      pipe_shift;
    logic [2:0]        div_cnt;
    logic [2:0]        div_last_q;
    logic              tick;
    pipe_state_t       state;
    pipe_state_t       state_nxt;
    logic              rd_req;
    logic              ufl_hit;
    logic [DATA_W-1:0] fifo_q;

    // Upstream flow control. Once a memory cycle is in flight the stage stays
    // enabled until its data has been collected, so en_up only drops on a full
    // FIFO or an idle pipe above the low mark.
    assign mem_busy   = |mem_pipe;
    assign en_up      = (mem_busy | (nword < LOW_CNT)) & (nword != FULL_CNT);
    assign csr_stb_o  = up_stb_i & en_up;
    assign pipe_shift = {mem_pipe, csr_stb_o};

    // The pipe only advances on enabled upstream cycles, mirroring how the
    // upstream stage itself stalls while en_up is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_pipe <= '0;
        end else if (en_up) begin
            mem_pipe <= pipe_shift[LAT-1:0];
        end
    end

    // Drain rate divider; the new rate is latched only at the wrap so a change
    // never produces a short or long first period.
    assign tick = (div_cnt == div_last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            div_last_q <= '0;
        end else if (tick) begin
            div_cnt    <= '0;
            div_last_q <= div_last(div_sel);
        end else begin
            div_cnt <= div_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PRIME;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_req    = 1'b0;
        ufl_hit   = 1'b0;
        case (state)
            PRIME: begin
                if (nword >= LOW_CNT) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    if (nword == '0) begin
                        ufl_hit   = 1'b1;
                        state_nxt = PRIME;
                    end else begin
                        rd_req = 1'b1;
                    end
                end
            end
            default: state_nxt = PRIME;
        endcase
    end

    // An underflow tick still pulses dn_en so pal_dac keeps its timing, but
    // repeats the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_dat <= '0;
            dn_en  <= 1'b0;
        end else begin
            dn_en <= rd_req | ufl_hit;
            if (rd_req) begin
                dn_dat <= fifo_q;
            end
        end
    end

`ifdef VGA_LCD_UNDERFLOW_CNT_EN
    logic [UCNT_W-1:0] ucnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ucnt <= '0;
        end else if (ufl_hit && (ucnt != {UCNT_W{1'b1}})) begin
            ucnt <= ucnt + 1'b1;
        end
    end

    assign underflow_cnt = ucnt;
`else
    assign underflow_cnt = '0;
`endif

    // No soft-clear source exists at this level; reset alone empties the FIFO.
    vga_lcd_fifo #(
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .wreq  (en_up),
        .d     (up_dat),
        .rreq  (rd_req),
        .q     (fifo_q),
        .nword (nword)
    );

endmodule

// File: tb/tb_vga_lcd_pipe.sv
// tb/tb_vga_lcd_pipe.sv - self-checking bench for vga_lcd_pipe

module tb_vga_lcd_pipe;

`ifdef VGA_LCD_UNDERFLOW_CNT_EN
    localparam bit UCNT_ON = 1'b1;
`else
    localparam bit UCNT_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [1:0]  div_sel;
    logic [11:0] up_dat;
    logic        up_stb_i;
    logic        en_up;
    logic        csr_stb_o;
    logic [11:0] dn_dat;
    logic        dn_en;
    logic [4:0]  nword;
    logic        mem_busy;
    logic [15:0] underflow_cnt;

    logic        lo_rst_n;
    logic [1:0]  lo_div;
    logic [11:0] lo_dat;
    logic        lo_stb;
    logic        lo_en_up;
    logic        lo_csr;
    logic [11:0] lo_dn_dat;
    logic        lo_dn_en;
    logic [4:0]  lo_nword;
    logic        lo_busy;
    logic [15:0] lo_ucnt;

    int checks = 0;
    int errors = 0;

    vga_lcd_pipe dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .div_sel       (div_sel),
        .up_dat        (up_dat),
        .up_stb_i      (up_stb_i),
        .en_up         (en_up),
        .csr_stb_o     (csr_stb_o),
        .dn_dat        (dn_dat),
        .dn_en         (dn_en),
        .nword         (nword),
        .mem_busy      (mem_busy),
        .underflow_cnt (underflow_cnt)
    );

    // Low mark of 1 lets the FIFO actually run dry, exposing the underflow path.
    vga_lcd_pipe #(.LOW_MARK(1)) u_lo (
        .clk           (clk),
        .rst_n         (lo_rst_n),
        .div_sel       (lo_div),
        .up_dat        (lo_dat),
        .up_stb_i      (lo_stb),
        .en_up         (lo_en_up),
        .csr_stb_o     (lo_csr),
        .dn_dat        (lo_dn_dat),
        .dn_en         (lo_dn_en),
        .nword         (lo_nword),
        .mem_busy      (lo_busy),
        .underflow_cnt (lo_ucnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference model: FIFO contents as a queue, in-flight memory cycles as a
    // list of remaining enabled-cycle lifetimes, drain timing as phase/period.
    logic [11:0] mq[$];
    int          m_rem[$];
    bit          m_run;
    int          m_phase;
    int          m_period;
    logic [11:0] m_dat;
    bit          m_en;
    int          m_ucnt;
    bit          stim_stb;
    logic [1:0]  stim_div;

    task automatic model_reset();
        mq.delete();
        m_rem.delete();
        m_run    = 1'b0;
        m_phase  = 0;
        m_period = 1;
        m_dat    = '0;
        m_en     = 1'b0;
        m_ucnt   = 0;
    endtask

    // One clock of the main DUT in lockstep with the model.
    task automatic step();
        int          nw;
        bit          busy;
        bit          en;
        bit          tick;
        int          exp_u;
        logic [11:0] d;
        d        = 12'($urandom);
        up_dat   = d;
        up_stb_i = stim_stb;
        div_sel  = stim_div;
        #1;
        nw   = mq.size();
        busy = (m_rem.size() != 0);
        en   = (busy || nw < 8) && (nw != 16);
        tick = (m_phase == m_period - 1);
        checks++;
        if (en_up !== en) begin
            errors++;
            $display("FAIL en_up: got %b expected %b (nword %0d)", en_up, en, nw);
        end
        checks++;
        if (csr_stb_o !== (stim_stb && en)) begin
            errors++;
            $display("FAIL csr_stb_o: got %b expected %b", csr_stb_o, stim_stb && en);
        end
        m_en = 1'b0;
        if (m_run) begin
            if (tick) begin
                if (nw > 0) begin
                    m_dat = mq.pop_front();
                    m_en  = 1'b1;
                end else begin
                    m_en = 1'b1;
                    if (m_ucnt < 65535) m_ucnt++;
                    m_run = 1'b0;
                end
            end
        end else if (nw >= 8) begin
            m_run = 1'b1;
        end
        if (en) begin
            mq.push_back(d);
            foreach (m_rem[i]) m_rem[i]--;
            while (m_rem.size() > 0 && m_rem[0] == 0) m_rem.delete(0);
            if (stim_stb) m_rem.push_back(4);
        end
        if (tick) begin
            m_phase  = 0;
            m_period = 1 << stim_div;
        end else begin
            m_phase++;
        end
        @(negedge clk);
        exp_u = UCNT_ON ? m_ucnt : 0;
        checks++;
        if (nword !== 5'(mq.size())) begin
            errors++;
            $display("FAIL nword: got %0d expected %0d", nword, mq.size());
        end
        checks++;
        if (dn_en !== m_en) begin
            errors++;
            $display("FAIL dn_en: got %b expected %b", dn_en, m_en);
        end
        checks++;
        if (dn_dat !== m_dat) begin
            errors++;
            $display("FAIL dn_dat: got %h expected %h", dn_dat, m_dat);
        end
        checks++;
        if (mem_busy !== (m_rem.size() != 0)) begin
            errors++;
            $display("FAIL mem_busy: got %b expected %b", mem_busy, m_rem.size() != 0);
        end
        checks++;
        if (underflow_cnt !== 16'(exp_u)) begin
            errors++;
            $display("FAIL underflow_cnt: got %0d expected %0d", underflow_cnt, exp_u);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        up_stb_i = 1'b1;
        div_sel  = 2'b00;
        up_dat   = '0;
        @(negedge clk);
        #1;
        checks++;
        if ({dn_dat, dn_en, nword, mem_busy, underflow_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_regs: got dat=%h en=%b nw=%0d busy=%b u=%0d expected all 0",
                     dn_dat, dn_en, nword, mem_busy, underflow_cnt);
        end
        checks++;
        if (en_up !== 1'b1) begin
            errors++;
            $display("FAIL reset_en_up: got %b expected 1", en_up);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        int first_en = -1;
        int max_nw   = 0;
        stim_stb = 1'b1;
        stim_div = 2'b00;
        for (int k = 0; k < 40; k++) begin
            step();
            if (dn_en === 1'b1 && first_en < 0) first_en = k;
            if (int'(nword) > max_nw) max_nw = int'(nword);
        end
        checks++;
        if (first_en != 9) begin
            errors++;
            $display("FAIL fill_first_dn_en: got cycle %0d expected cycle 9", first_en);
        end
        checks++;
        if (max_nw > 16) begin
            errors++;
            $display("FAIL fill_max_nword: got %0d expected <=16", max_nw);
        end
    endtask

    task automatic test_steady();
        int last = -1;
        stim_stb = 1'b0;
        stim_div = 2'b10;
        for (int k = 0; k < 120; k++) step();
        for (int k = 0; k < 40; k++) begin
            step();
            if (dn_en === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (k - last != 4) begin
                        errors++;
                        $display("FAIL steady_gap: got %0d expected 4", k - last);
                    end
                end
                last = k;
            end
        end
        checks++;
        if (last < 0 || nword < 5'd6 || nword > 5'd9) begin
            errors++;
            $display("FAIL steady_level: got nword %0d (last dn_en %0d) expected 6..9", nword, last);
        end
        checks++;
        if (underflow_cnt !== 16'd0) begin
            errors++;
            $display("FAIL steady_ucnt: got %0d expected 0", underflow_cnt);
        end
    endtask

    task automatic test_full_drain();
        bit seen_full = 1'b0;
        bit seen_low  = 1'b0;
        bit reassert  = 1'b0;
        stim_stb = 1'b1;
        stim_div = 2'b11;
        for (int k = 0; k < 200 && !seen_full; k++) begin
            step();
            if (nword === 5'd16) seen_full = 1'b1;
        end
        checks++;
        if (!seen_full) begin
            errors++;
            $display("FAIL full_reach: got nword %0d expected 16", nword);
        end
        for (int k = 0; k < 24; k++) begin
            step();
            if (en_up === 1'b0) begin
                seen_low = 1'b1;
                checks++;
                if (csr_stb_o !== 1'b0) begin
                    errors++;
                    $display("FAIL full_csr_gate: got %b expected 0", csr_stb_o);
                end
            end
        end
        checks++;
        if (!seen_low) begin
            errors++;
            $display("FAIL full_en_low: got en_up never low expected low when full");
        end
        stim_stb = 1'b0;
        for (int k = 0; k < 400 && !reassert; k++) begin
            step();
            if (en_up === 1'b1 && mem_busy === 1'b0) reassert = 1'b1;
        end
        checks++;
        if (!reassert || nword !== 5'd7) begin
            errors++;
            $display("FAIL drain_reassert: got en_up=%b nword=%0d expected en_up=1 at nword 7",
                     en_up, nword);
        end
    endtask

    task automatic test_pulse();
        int busy_cycles = 0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n    = 1'b1;
        stim_div = 2'b00;
        stim_stb = 1'b1;
        step();
        if (mem_busy === 1'b1) busy_cycles++;
        stim_stb = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (mem_busy === 1'b1) busy_cycles++;
        end
        checks++;
        if (busy_cycles != 4) begin
            errors++;
            $display("FAIL pulse_busy: got %0d cycles expected 4", busy_cycles);
        end
    endtask

    task automatic test_reset_mid();
        bit hit      = 1'b0;
        int first_en = -1;
        stim_stb = 1'b1;
        stim_div = 2'b11;
        for (int k = 0; k < 200 && nword !== 5'd16; k++) step();
        stim_stb = 1'b0;
        for (int k = 0; k < 300 && !hit; k++) begin
            step();
            if (nword === 5'd12) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL mid_reach12: got nword %0d expected 12", nword);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dn_dat, dn_en, nword, mem_busy, underflow_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_async_reset: got dat=%h en=%b nw=%0d busy=%b u=%0d expected all 0",
                     dn_dat, dn_en, nword, mem_busy, underflow_cnt);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        stim_stb = 1'b1;
        stim_div = 2'b00;
        for (int k = 0; k < 16; k++) begin
            step();
            if (dn_en === 1'b1 && first_en < 0) first_en = k;
        end
        checks++;
        if (first_en != 9) begin
            errors++;
            $display("FAIL mid_first_dn_en: got cycle %0d expected cycle 9", first_en);
        end
    endtask

    task automatic test_starve();
        logic [11:0] d[16];
        lo_stb = 1'b0;
        lo_div = 2'b00;
        for (int c = 0; c < 15; c++) begin
            lo_rst_n = 1'b1;
            d[c]     = 12'($urandom);
            lo_dat   = d[c];
            @(negedge clk);
            case (c)
                2: begin
                    checks++;
                    if (lo_dn_en !== 1'b1 || lo_dn_dat !== d[0]) begin
                        errors++;
                        $display("FAIL starve_pop: got en=%b dat=%h expected en=1 dat=%h",
                                 lo_dn_en, lo_dn_dat, d[0]);
                    end
                end
                3: begin
                    checks++;
                    if (lo_dn_en !== 1'b1 || lo_dn_dat !== d[0]) begin
                        errors++;
                        $display("FAIL starve_hold: got en=%b dat=%h expected en=1 dat=%h",
                                 lo_dn_en, lo_dn_dat, d[0]);
                    end
                    checks++;
                    if (lo_ucnt !== (UCNT_ON ? 16'd1 : 16'd0)) begin
                        errors++;
                        $display("FAIL starve_ucnt1: got %0d expected %0d", lo_ucnt, UCNT_ON ? 1 : 0);
                    end
                end
                4: begin
                    checks++;
                    if (lo_dn_en !== 1'b0 || lo_nword !== 5'd1) begin
                        errors++;
                        $display("FAIL starve_prime: got en=%b nword=%0d expected en=0 nword=1",
                                 lo_dn_en, lo_nword);
                    end
                end
                5: begin
                    checks++;
                    if (lo_dn_en !== 1'b1 || lo_dn_dat !== d[3]) begin
                        errors++;
                        $display("FAIL starve_resume: got en=%b dat=%h expected en=1 dat=%h",
                                 lo_dn_en, lo_dn_dat, d[3]);
                    end
                end
                14: begin
                    checks++;
                    if (lo_ucnt !== (UCNT_ON ? 16'd4 : 16'd0)) begin
                        errors++;
                        $display("FAIL starve_ucnt4: got %0d expected %0d", lo_ucnt, UCNT_ON ? 4 : 0);
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        lo_rst_n = 1'b0;
        lo_div   = 2'b00;
        lo_dat   = '0;
        lo_stb   = 1'b0;
        stim_stb = 1'b0;
        stim_div = 2'b00;
        model_reset();
        test_reset();
        test_fill();
        test_steady();
        test_full_drain();
        test_pulse();
        test_reset_mid();
        test_starve();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_lcd_pipe.md
VGA_LCD_PIPE -- requirements
Module: vga_lcd_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 12, meaning the packed pixel/sync word width.
REQ-002 SHALL have parameter AW, default 4, meaning the FIFO depth of 2^AW words.
REQ-003 SHALL have parameter LAT, default 4, meaning the memory-cycle pipe depth in upstream enables.
REQ-004 SHALL have parameter LOW_MARK, default 8, meaning the fill threshold in words (1..2^AW-1).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic runs on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-007 SHALL have port div_sel, input, 2, the drain rate: 00 /1, 01 /2, 10 /4, 11 /8.
REQ-008 SHALL have port up_dat, input, DATA_W, the word from the upstream (crtc/sequencer) stage.
REQ-009 SHALL have port up_stb_i, input, 1, the raw upstream memory strobe.
REQ-010 SHALL have port en_up, output, 1, the upstream stage enable.
REQ-011 SHALL have port csr_stb_o, output, 1, the gated memory strobe.
REQ-012 SHALL have port dn_dat, output, DATA_W, the word presented to pal_dac.
REQ-013 SHALL have port dn_en, output, 1, the pal_dac enable pulse.
REQ-014 SHALL have port nword, output, AW+1, the FIFO occupancy.
REQ-015 SHALL have port mem_busy, output, 1, high while any memory-pipe bit is set.
REQ-016 SHALL have port underflow_cnt, output, 16, the count of drain ticks that found the FIFO empty.

Function
REQ-017 SHALL drive mem_busy as the OR of the LAT-bit pipe, which shifts in csr_stb_o only on cycles with en_up=1.
REQ-018 SHALL drive en_up = (mem_busy | nword<LOW_MARK) & (nword!=2^AW).
REQ-019 SHALL drive csr_stb_o = up_stb_i & en_up.
REQ-020 SHALL write up_dat into the FIFO on every cycle with en_up=1; the FIFO never overflows.
REQ-021 SHALL run a 3-bit drain counter that raises a tick every 1/2/4/8 cycles per div_sel; a div_sel change takes effect at the next counter wrap.
REQ-022 SHALL use states PRIME and RUN: PRIME issues no reads; PRIME->RUN when nword>=LOW_MARK; RUN->PRIME on an underflow.
REQ-023 SHALL in RUN, on a tick with the FIFO non-empty, pop one word, register it to dn_dat and pulse dn_en one cycle later (latency 1).
REQ-024 SHALL in RUN, on a tick with the FIFO empty, hold dn_dat, pulse dn_en, increment underflow_cnt saturating at 0xFFFF, and enter PRIME.
REQ-025 SHALL on a simultaneous read and write leave nword unchanged; a write to an empty FIFO is not readable in the same cycle.
REQ-026 SHALL wrap the FIFO pointers modulo 2^AW and keep nword in 0..2^AW.

Reset
REQ-027 SHALL on rst_n low clear immediately: the FIFO pointers, nword, mem pipe, drain counter, dn_dat, dn_en and underflow_cnt, and set the state to PRIME.
REQ-028 SHALL on a reset mid-burst discard all FIFO contents; the first dn_en after release follows a fresh PRIME.

Configuration
REQ-029 SHALL with VGA_LCD_UNDERFLOW_CNT_EN defined include the saturating counter of REQ-024.
REQ-030 SHALL with VGA_LCD_UNDERFLOW_CNT_EN undefined tie underflow_cnt to 0, leaving the state behaviour unchanged.

Structure
REQ-031 SHALL place in package vga_lcd_pkg: the div_sel encodings, the PRIME/RUN state typedef and the 16-bit counter width constant.
REQ-032 SHALL put the storage in sub-module vga_lcd_fifo (DATA_W, AW; wreq/rreq/q/nword; sync clear plus async reset).

Verification
REQ-033 SHALL cover: reset release with up_stb_i=1, div_sel=00 -> en_up high, first dn_en after 8 writes, nword never >16.
REQ-034 SHALL cover: div_sel=10 in steady state -> dn_en every 4 cycles, nword settles near 8, underflow_cnt=0.
REQ-035 SHALL cover: force en_up low via a full FIFO, then drain -> en_up reasserts when nword<8; csr_stb_o=0 while en_up=0.
REQ-036 SHALL cover: single up_stb_i pulse -> mem_busy high for exactly 4 enabled cycles.
REQ-037 SHALL cover: starve upstream in RUN -> underflow_cnt=1, dn_dat held, state PRIME until nword>=8.
REQ-038 SHALL cover: rst_n asserted with nword=12 mid-drain -> all outputs 0 asynchronously; with the macro undefined, underflow_cnt stays 0 under starvation.
